// File: rtl/cache_ri_ctrl.sv
// cache_ri_ctrl: refill / uncached-IO sequencer behind the cache front end.
// Ports: cmd valid/ready channel (cmd, req_*), IO read return (io_*),
//   memory master (m1_*), data/tag/readable-byte RAM write ports (data_*, tag_*, dre_*).
module cache_ri_ctrl #(
    parameter int DATA_ADDR_WIDTH = 9,
    parameter int LINE_LOG2       = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                 clk,
    input  logic                                 rest,
    input  logic [3:0]                           cmd,
    input  logic                                 cmd_valid,
    output logic                                 cmd_ready,
    input  logic [31:0]                          req_address,
    input  logic                                 req_write,
    input  logic [3:0]                           req_byteEnable,
    input  logic [31:0]                          req_writeData,
    input  logic [1:0]                           req_way,
    output logic [31:0]                          io_readData,
    output logic                                 io_readValid,
    output logic [31:0]                          m1_address,
    output logic [3:0]                           m1_byteEnable,
    output logic                                 m1_read,
    output logic                                 m1_write,
    output logic [31:0]                          m1_writeData,
    input  logic                                 m1_waitRequest,
    input  logic [31:0]                          m1_readData,
    input  logic                                 m1_readDataValid,
    output logic [DATA_ADDR_WIDTH-1:0]           data_wAddr,
    output logic [1:0]                           data_wCh,
    output logic [31:0]                          data_wData,
    output logic                                 data_wEn,
    output logic [3:0]                           data_wByteEn,
    output logic [DATA_ADDR_WIDTH-LINE_LOG2-1:0] tag_wAddr,
    output logic [31:0]                          tag_wData,
    output logic                                 tag_wEn,
    output logic                                 dre_wEn,
    output logic [7:0]                           dre_wData
);
    localparam int TAG_W = 32 - DATA_ADDR_WIDTH - 2;
    localparam int SET_W = DATA_ADDR_WIDTH - LINE_LOG2;
    localparam int CNT_W = LINE_LOG2 + 1;
    localparam logic [CNT_W-1:0] LINE_WORDS = CNT_W'(1 << LINE_LOG2);
    localparam logic [CNT_W-1:0] LAST_WORD  = CNT_W'((1 << LINE_LOG2) - 1);
    localparam logic [CNT_W-1:0] MAX_OUT    = CNT_W'(MAX_OUTSTANDING);
    localparam logic [3:0] CMD_RB   = 4'd1;
    localparam logic [3:0] CMD_IORW = 4'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CTRL,
        S_IO_REQ,
        S_IO_WAIT,
        S_RB_RUN,
        S_TAG_WR,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [29:0]       r_aw;
    logic [1:0]        r_way;
    logic              r_write;
    logic [3:0]        r_be;
    logic [31:0]       r_wdata;
    logic [CNT_W-1:0]  r_iss;
    logic [CNT_W-1:0]  r_rcv;
    logic [31:0]       r_io_rdata;
    logic              r_io_rvalid;

    logic [SET_W-1:0]  w_set;
    logic [TAG_W-1:0]  w_tag;
    logic [31:0]       w_tag_word;
    logic [CNT_W-1:0]  w_inflight;
    logic              w_iss_ok;
    logic              w_iss_acc;
    logic              w_ret;
    logic              w_unused;

    // Byte offset is irrelevant: every memory access is word aligned.
    assign w_unused   = ^req_address[1:0];

    assign w_set      = r_aw[DATA_ADDR_WIDTH-1:LINE_LOG2];
    assign w_tag      = r_aw[29:DATA_ADDR_WIDTH];
    assign w_tag_word = {{(31 - TAG_W){1'b0}}, 1'b1, w_tag};

    // Issue window: stop at end of line or when the in-flight limit is reached.
    assign w_inflight = r_iss - r_rcv;
    assign w_iss_ok   = (r_iss < LINE_WORDS) && (w_inflight < MAX_OUT);
    assign w_iss_acc  = (r_state == S_RB_RUN) && w_iss_ok && !m1_waitRequest;
    // Returns beyond the line are stray and dropped.
    assign w_ret      = (r_state == S_RB_RUN) && m1_readDataValid
                        && (r_rcv < LINE_WORDS);

    assign io_readData  = r_io_rdata;
    assign io_readValid = r_io_rvalid;

    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            r_aw        <= '0;
            r_way       <= '0;
            r_write     <= 1'b0;
            r_be        <= '0;
            r_wdata     <= '0;
            r_iss       <= '0;
            r_rcv       <= '0;
            r_io_rdata  <= '0;
            r_io_rvalid <= 1'b0;
        end else begin
            r_io_rvalid <= 1'b0;
            if (r_state == S_IDLE && cmd_valid) begin
                r_aw    <= req_address[31:2];
                r_way   <= req_way;
                r_write <= req_write;
                r_be    <= req_byteEnable;
                r_wdata <= req_writeData;
                r_iss   <= '0;
                r_rcv   <= '0;
            end
            if (w_iss_acc) begin
                r_iss <= r_iss + CNT_W'(1);
            end
            if (w_ret) begin
                r_rcv <= r_rcv + CNT_W'(1);
            end
            if (r_state == S_IO_WAIT && m1_readDataValid) begin
                r_io_rdata  <= m1_readData;
                r_io_rvalid <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        cmd_ready     = 1'b0;
        m1_address    = '0;
        m1_byteEnable = '0;
        m1_read       = 1'b0;
        m1_write      = 1'b0;
        m1_writeData  = '0;
        data_wAddr    = '0;
        data_wCh      = '0;
        data_wData    = '0;
        data_wEn      = 1'b0;
        data_wByteEn  = '0;
        dre_wEn       = 1'b0;
        dre_wData     = '0;
        tag_wAddr     = '0;
        tag_wData     = '0;
        tag_wEn       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (cmd == CMD_RB) begin
                        w_state_nxt = S_RB_RUN;
                    end else if (cmd == CMD_IORW) begin
                        w_state_nxt = S_IO_REQ;
                    end else begin
                        w_state_nxt = S_CTRL;
                    end
                end
            end
            S_CTRL: begin
                w_state_nxt = S_DONE;
            end
            S_IO_REQ: begin
                m1_address    = {r_aw, 2'b00};
                m1_byteEnable = r_be;
                m1_read       = !r_write;
                m1_write      = r_write;
                m1_writeData  = r_wdata;
                if (!m1_waitRequest) begin
                    w_state_nxt = r_write ? S_DONE : S_IO_WAIT;
                end
            end
            S_IO_WAIT: begin
                if (m1_readDataValid) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_RB_RUN: begin
                m1_address   = {r_aw[29:LINE_LOG2], r_iss[LINE_LOG2-1:0], 2'b00};
                m1_read      = w_iss_ok;
                m1_byteEnable = w_iss_ok ? 4'hF : 4'h0;
                data_wAddr   = {w_set, r_rcv[LINE_LOG2-1:0]};
                data_wCh     = r_way;
                data_wByteEn = 4'hF;
                if (w_ret) begin
                    data_wData = m1_readData;
                    data_wEn   = 1'b1;
                    dre_wEn    = 1'b1;
                    dre_wData  = 8'hFF;
                    // Leave on the last word's write; tag goes in next cycle.
                    if (r_rcv == LAST_WORD) begin
                        w_state_nxt = S_TAG_WR;
                    end
                end
            end
            S_TAG_WR: begin
                tag_wEn     = 1'b1;
                tag_wAddr   = w_set;
                tag_wData   = w_tag_word;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                cmd_ready   = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_cache_ri_ctrl.sv
// tb_cache_ri_ctrl: directed bench for cache_ri_ctrl with a memory responder
// and an event-queue model checked on every cycle.
module tb_cache_ri_ctrl;
    logic        clk = 1'b0;
    logic        rest = 1'b1;
    logic [3:0]  cmd = '0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] req_address = '0;
    logic        req_write = 1'b0;
    logic [3:0]  req_byteEnable = '0;
    logic [31:0] req_writeData = '0;
    logic [1:0]  req_way = '0;
    logic [31:0] io_readData;
    logic        io_readValid;
    logic [31:0] m1_address;
    logic [3:0]  m1_byteEnable;
    logic        m1_read;
    logic        m1_write;
    logic [31:0] m1_writeData;
    logic        m1_waitRequest;
    logic [31:0] m1_readData;
    logic        m1_readDataValid;
    logic [8:0]  data_wAddr;
    logic [1:0]  data_wCh;
    logic [31:0] data_wData;
    logic        data_wEn;
    logic [3:0]  data_wByteEn;
    logic [4:0]  tag_wAddr;
    logic [31:0] tag_wData;
    logic        tag_wEn;
    logic        dre_wEn;
    logic [7:0]  dre_wData;

    cache_ri_ctrl dut (
        .clk(clk), .rest(rest), .cmd(cmd), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .req_address(req_address),
        .req_write(req_write), .req_byteEnable(req_byteEnable),
        .req_writeData(req_writeData), .req_way(req_way),
        .io_readData(io_readData), .io_readValid(io_readValid),
        .m1_address(m1_address), .m1_byteEnable(m1_byteEnable),
        .m1_read(m1_read), .m1_write(m1_write),
        .m1_writeData(m1_writeData), .m1_waitRequest(m1_waitRequest),
        .m1_readData(m1_readData), .m1_readDataValid(m1_readDataValid),
        .data_wAddr(data_wAddr), .data_wCh(data_wCh),
        .data_wData(data_wData), .data_wEn(data_wEn),
        .data_wByteEn(data_wByteEn), .tag_wAddr(tag_wAddr),
        .tag_wData(tag_wData), .tag_wEn(tag_wEn),
        .dre_wEn(dre_wEn), .dre_wData(dre_wData)
    );

    always #5 clk = ~clk;

    int n_tot = 0;
    int n_pass = 0;
    int cyc = 0;

    logic [31:0] exp_rd_q[$];
    logic [31:0] exp_mw_addr_q[$];
    logic [31:0] exp_mw_data_q[$];
    logic [3:0]  exp_mw_be_q[$];
    logic [8:0]  exp_dw_addr_q[$];
    logic [1:0]  exp_dw_way_q[$];
    logic [31:0] exp_dw_data_q[$];
    logic [31:0] pend_data_q[$];
    int          pend_due_q[$];
    bit          exp_tag = 0;
    logic [4:0]  exp_tag_addr = '0;
    logic [31:0] exp_tag_data = '0;
    bit          exp_io = 0;
    logic [31:0] exp_io_data = '0;
    bit          mode_io = 0;
    logic [3:0]  exp_io_be = '0;
    logic [31:0] io_data = '0;
    int          lat = 1;
    int          stall_left = 0;
    int          spur_req = 0;

    int acc_rb, rd_acc, wr_cnt, tag_cnt, io_cnt, act_cnt, mw_cnt, max_out;
    logic [31:0] first_rd, last_rd, last_tag_data;
    logic [8:0]  first_dw, last_dw;
    logic [4:0]  last_tag_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h0001_0003) ^ 32'hA5C3_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic fail_unexp(input string name, input logic [31:0] act);
        n_tot++;
        $display("FAIL %s: got unexpected event value %h want none", name, act);
    endtask

    function automatic logic any_out();
        return |{cmd_ready, io_readData, io_readValid, m1_address,
                 m1_byteEnable, m1_read, m1_write, m1_writeData,
                 data_wAddr, data_wCh, data_wData, data_wEn, data_wByteEn,
                 tag_wAddr, tag_wData, tag_wEn, dre_wEn, dre_wData};
    endfunction

    task automatic flush_model();
        exp_rd_q.delete();
        exp_mw_addr_q.delete();
        exp_mw_data_q.delete();
        exp_mw_be_q.delete();
        exp_dw_addr_q.delete();
        exp_dw_way_q.delete();
        exp_dw_data_q.delete();
        pend_data_q.delete();
        pend_due_q.delete();
        exp_tag = 0;
        exp_io = 0;
        stall_left = 0;
        spur_req = 0;
    endtask

    task automatic clear_counts();
        acc_rb = 0; rd_acc = 0; wr_cnt = 0; tag_cnt = 0;
        io_cnt = 0; act_cnt = 0; mw_cnt = 0; max_out = 0;
        first_rd = '0; last_rd = '0; first_dw = '0; last_dw = '0;
        last_tag_addr = '0; last_tag_data = '0;
    endtask

    // A line is 16 words = 64 bytes; data RAM word index = (addr>>2) mod 512.
    task automatic plan_rb(input logic [31:0] a, input logic [1:0] way);
        logic [31:0] base;
        logic [31:0] dbase;
        base  = a & 32'hFFFF_FFC0;
        dbase = (a >> 2) & 32'h0000_01F0;
        for (int k = 0; k < 16; k++) begin
            exp_rd_q.push_back(base + 32'(4 * k));
            exp_dw_addr_q.push_back(9'(dbase + 32'(k)));
            exp_dw_way_q.push_back(way);
            exp_dw_data_q.push_back(mem_word(base + 32'(4 * k)));
        end
        exp_tag      = 1;
        exp_tag_addr = 5'((a >> 6) & 32'h1F);
        exp_tag_data = 32'h0020_0000 | (a >> 11);
        mode_io      = 0;
    endtask

    // Responder + compare process: drive inputs at negedge, check 1 ns later.
    initial begin
        m1_waitRequest   = 1'b0;
        m1_readDataValid = 1'b0;
        m1_readData      = '0;
        forever begin
            @(negedge clk);
            cyc++;
            m1_readDataValid = 1'b0;
            m1_readData      = '0;
            m1_waitRequest   = 1'b0;
            if (rest) begin
                flush_model();
                continue;
            end
            if (pend_due_q.size() > 0 && pend_due_q[0] <= cyc) begin
                m1_readDataValid = 1'b1;
                m1_readData      = pend_data_q.pop_front();
                void'(pend_due_q.pop_front());
            end else if (spur_req > 0) begin
                m1_readDataValid = 1'b1;
                m1_readData      = 32'h0BAD_0BAD;
                spur_req--;
            end
            if ((m1_read || m1_write) && stall_left > 0) begin
                m1_waitRequest = 1'b1;
                stall_left--;
            end
            #1;
            if (rest) continue;
            if (m1_read && m1_write) fail_unexp("m1_rd_wr_both", m1_address);
            if (m1_read || m1_write) act_cnt++;
            if (mode_io && (m1_read || m1_write))
                chk("io_be", 32'(m1_byteEnable), 32'(exp_io_be));
            if (m1_read && !m1_waitRequest) begin
                if (exp_rd_q.size() == 0) begin
                    fail_unexp("rd_issue", m1_address);
                end else begin
                    chk("rd_addr", m1_address, exp_rd_q.pop_front());
                    if (rd_acc == 0) first_rd = m1_address;
                    last_rd = m1_address;
                    rd_acc++;
                    if (mode_io) begin
                        pend_data_q.push_back(io_data);
                    end else begin
                        chk("rd_window", 32'((acc_rb - wr_cnt) < 4), 32'd1);
                        acc_rb++;
                        pend_data_q.push_back(mem_word(m1_address));
                    end
                    pend_due_q.push_back(cyc + lat);
                end
            end
            if (m1_write && !m1_waitRequest) begin
                if (exp_mw_addr_q.size() == 0) begin
                    fail_unexp("wr_issue", m1_address);
                end else begin
                    chk("mw_addr", m1_address, exp_mw_addr_q.pop_front());
                    chk("mw_data", m1_writeData, exp_mw_data_q.pop_front());
                    chk("mw_be", 32'(m1_byteEnable), 32'(exp_mw_be_q.pop_front()));
                    mw_cnt++;
                end
            end
            if (data_wEn) begin
                if (exp_dw_addr_q.size() == 0) begin
                    fail_unexp("data_wEn", data_wData);
                end else begin
                    chk("dw_addr", 32'(data_wAddr), 32'(exp_dw_addr_q.pop_front()));
                    chk("dw_way", 32'(data_wCh), 32'(exp_dw_way_q.pop_front()));
                    chk("dw_data", data_wData, exp_dw_data_q.pop_front());
                    chk("dw_be", 32'(data_wByteEn), 32'h0000_000F);
                    chk("dre_wEn", 32'(dre_wEn), 32'd1);
                    chk("dre_wData", 32'(dre_wData), 32'h0000_00FF);
                    if (wr_cnt == 0) first_dw = data_wAddr;
                    last_dw = data_wAddr;
                    wr_cnt++;
                end
            end else if (dre_wEn) begin
                fail_unexp("dre_wEn_alone", 32'(dre_wData));
            end
            if (tag_wEn) begin
                tag_cnt++;
                last_tag_addr = tag_wAddr;
                last_tag_data = tag_wData;
                if (exp_tag && exp_dw_addr_q.size() == 0) begin
                    chk("tag_addr", 32'(tag_wAddr), 32'(exp_tag_addr));
                    chk("tag_data", tag_wData, exp_tag_data);
                    exp_tag = 0;
                end else begin
                    fail_unexp("tag_wEn", tag_wData);
                end
            end
            if (io_readValid) begin
                io_cnt++;
                if (exp_io) begin
                    chk("io_rdata", io_readData, exp_io_data);
                    exp_io = 0;
                end else begin
                    fail_unexp("io_readValid", io_readData);
                end
            end
            if (!mode_io && (acc_rb - wr_cnt) > max_out) max_out = acc_rb - wr_cnt;
        end
    end

    task automatic run_cmd(input logic [3:0] c, input logic [31:0] a,
                           input logic w, input logic [3:0] be,
                           input logic [31:0] wd, input logic [1:0] way,
                           output int l);
        @(negedge clk);
        cmd            = c;
        req_address    = a;
        req_write      = w;
        req_byteEnable = be;
        req_writeData  = wd;
        req_way        = way;
        cmd_valid      = 1'b1;
        l = 0;
        for (int i = 1; i <= 400; i++) begin
            @(posedge clk);
            #1;
            if (cmd_ready) begin
                l = i;
                break;
            end
        end
        cmd_valid = 1'b0;
        if (l == 0) fail_unexp("cmd_timeout", 32'(c));
        @(negedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int l;
        int n;
        clear_counts();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs_zero", 32'(any_out()), 32'd0);
        @(posedge clk);
        #3;
        rest = 1'b0;
        repeat (2) @(negedge clk);
        #2;

        // CTRL with stray read returns that must be ignored
        clear_counts();
        mode_io = 0;
        spur_req = 3;
        run_cmd(4'd3, 32'h0000_0100, 1'b0, 4'h0, '0, 2'd0, l);
        chk("ctrl_latency", 32'(l), 32'd2);
        chk("ctrl_no_m1", 32'(act_cnt), 32'd0);
        chk("ctrl_no_ram", 32'(wr_cnt + tag_cnt + io_cnt), 32'd0);

        // unknown command behaves as CTRL
        clear_counts();
        run_cmd(4'hF, 32'h0000_0200, 1'b0, 4'h0, '0, 2'd0, l);
        chk("ctrl_other_latency", 32'(l), 32'd2);
        chk("ctrl_other_no_m1", 32'(act_cnt), 32'd0);

        // IORW read with 3 wait cycles
        clear_counts();
        mode_io = 1;
        exp_io_be = 4'hF;
        io_data = 32'hDEAD_BEEF;
        stall_left = 3;
        exp_rd_q.push_back(32'h8000_0006 & 32'hFFFF_FFFC);
        exp_io = 1;
        exp_io_data = 32'hDEAD_BEEF;
        run_cmd(4'd2, 32'h8000_0006, 1'b0, 4'hF, '0, 2'd0, l);
        chk("io_rd_latency", 32'(l), 32'd6);
        chk("io_rd_addr_lit", first_rd, 32'h8000_0004);
        chk("io_rd_req_cycles", 32'(act_cnt), 32'd4);
        chk("io_rd_valid_cnt", 32'(io_cnt), 32'd1);
        chk("io_rd_data_out", io_readData, 32'hDEAD_BEEF);

        // IORW write
        clear_counts();
        mode_io = 1;
        exp_io_be = 4'b0011;
        exp_mw_addr_q.push_back(32'h4000_0012 & 32'hFFFF_FFFC);
        exp_mw_data_q.push_back(32'h0000_1234);
        exp_mw_be_q.push_back(4'b0011);
        run_cmd(4'd2, 32'h4000_0012, 1'b1, 4'b0011, 32'h0000_1234, 2'd0, l);
        chk("io_wr_latency", 32'(l), 32'd2);
        chk("io_wr_cnt", 32'(mw_cnt), 32'd1);
        chk("io_wr_no_ram", 32'(wr_cnt + tag_cnt + io_cnt), 32'd0);

        // refill, 1-cycle memory
        clear_counts();
        lat = 1;
        plan_rb(32'h0000_1234, 2'd2);
        run_cmd(4'd1, 32'h0000_1234, 1'b0, 4'h0, '0, 2'd2, l);
        chk("rb_latency", 32'(l), 32'd19);
        chk("rb_first_rd", first_rd, 32'h0000_1200);
        chk("rb_last_rd", last_rd, 32'h0000_123C);
        chk("rb_first_dw", 32'(first_dw), 32'h0000_0080);
        chk("rb_last_dw", 32'(last_dw), 32'h0000_008F);
        chk("rb_tag_addr_lit", 32'(last_tag_addr), 32'd8);
        chk("rb_tag_data_lit", last_tag_data, 32'h0020_0002);
        chk("rb_words", 32'(wr_cnt), 32'd16);
        chk("rb_tag_cnt", 32'(tag_cnt), 32'd1);
        chk("rb_max_out", 32'(max_out), 32'd1);
        chk("rb_left", 32'(exp_rd_q.size() + exp_dw_addr_q.size()), 32'd0);

        // refill, 10-cycle memory: in-flight window must fill to 4
        clear_counts();
        lat = 10;
        plan_rb(32'h0001_0FC0, 2'd1);
        run_cmd(4'd1, 32'h0001_0FC0, 1'b0, 4'h0, '0, 2'd1, l);
        chk("rb10_max_out", 32'(max_out), 32'd4);
        chk("rb10_words", 32'(wr_cnt), 32'd16);
        chk("rb10_tag_cnt", 32'(tag_cnt), 32'd1);
        chk("rb10_tag_addr_lit", 32'(last_tag_addr), 32'h0000_001F);
        chk("rb10_tag_data_lit", last_tag_data, 32'h0020_0021);
        chk("rb10_left", 32'(exp_rd_q.size() + exp_dw_addr_q.size()), 32'd0);

        // reset after the 7th refill word
        clear_counts();
        lat = 1;
        plan_rb(32'h0000_2340, 2'd3);
        @(negedge clk);
        cmd         = 4'd1;
        req_address = 32'h0000_2340;
        req_way     = 2'd3;
        cmd_valid   = 1'b1;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #2;
            if (wr_cnt >= 7) begin
                n = wr_cnt;
                break;
            end
        end
        chk("mid_words_before", 32'(n), 32'd7);
        @(posedge clk);
        #1;
        rest = 1'b1;
        cmd_valid = 1'b0;
        #1;
        chk("mid_reset_outs_zero", 32'(any_out()), 32'd0);
        repeat (2) @(posedge clk);
        #3;
        rest = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        chk("mid_tag_never", 32'(tag_cnt), 32'd0);
        chk("mid_words_after", 32'(wr_cnt), 32'd7);
        clear_counts();
        mode_io = 0;
        run_cmd(4'd3, 32'h0000_0000, 1'b0, 4'h0, '0, 2'd0, l);
        chk("post_reset_ctrl_latency", 32'(l), 32'd2);
        chk("post_reset_ctrl_no_m1", 32'(act_cnt), 32'd0);
        chk("post_reset_no_tag", 32'(tag_cnt + wr_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
